// File: rtl/transpose_ctrl_if.sv
// ---------------------------------------------------------------------------
// transpose_ctrl_if
// Bundles the streaming input, streaming output, completion pulse and the
// single-port RAM bus of the matrix transpose controller.
//
//   in_data/in_valid/in_ready    row-major element stream into the block
//   out_data/out_valid/out_ready transposed element stream out of the block
//   done                         one-cycle pulse after the last output word
//   ram_addr/ram_din/ram_we      RAM request (one access per cycle)
//   ram_q                        RAM read data, one cycle after a read
//
// slave  : the transpose controller itself
// master : the surrounding logic (stream source/sink and the RAM)
// ---------------------------------------------------------------------------
interface transpose_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM_LOG2   = 3
);
    localparam int ADDR_WIDTH = 2 * DIM_LOG2;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    modport slave (
        input  in_data, in_valid, out_ready, ram_q,
        output in_ready, out_data, out_valid, done, ram_addr, ram_din, ram_we
    );

    modport master (
        output in_data, in_valid, out_ready, ram_q,
        input  in_ready, out_data, out_valid, done, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/transpose_ctrl.sv
// ---------------------------------------------------------------------------
// transpose_ctrl
// Loads an N x N matrix (N = 2**DIM_LOG2) into an external single-port RAM in
// row-major order, then reads it back column by column so the output stream
// is the transpose. Read latency of the RAM is one cycle; read data lands in
// a two-entry output FIFO (output register plus skid register) so the output
// stream can stall without losing words.
//
// Ports
//   clk    : sole clock
//   reset  : synchronous, active-high; abandons any matrix in progress
//   bus    : transpose_ctrl_if.slave (stream in, stream out, done, RAM bus)
// ---------------------------------------------------------------------------
module transpose_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM_LOG2   = 3
) (
    input  logic             clk,
    input  logic             reset,
    transpose_ctrl_if.slave  bus
);
    localparam int ADDR_WIDTH = 2 * DIM_LOG2;
    localparam int WORDS      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   WORDS_K   = (ADDR_WIDTH + 1)'(WORDS);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wrCnt;
    logic [ADDR_WIDTH:0]   r_k;
    logic [ADDR_WIDTH-1:0] r_outCnt;
    logic                  r_inFlight;
    logic                  r_outValid;
    logic [DATA_WIDTH-1:0] r_outData;
    logic                  r_skidValid;
    logic [DATA_WIDTH-1:0] r_skidData;
    logic                  r_done;

    logic                  w_write;
    logic                  w_read;
    logic                  w_outHs;
    logic                  w_lastOut;
    logic [1:0]            w_pending;
    logic [ADDR_WIDTH-1:0] w_rdAddr;

    // Access decision for this cycle. Writes only happen in LOAD, reads only
    // in DRAIN, so the RAM never sees two accesses at once. A read is only
    // launched when the word it returns is guaranteed a free FIFO slot:
    // buffered words plus the word still in flight, minus the one leaving on
    // the output this cycle, must stay below two. The read address swaps the
    // row and column halves of the output index.
    always_comb begin
        w_write   = !reset && (r_state == LOAD) && bus.in_valid;
        w_outHs   = r_outValid && bus.out_ready;
        w_lastOut = w_outHs && (r_outCnt == LAST_ADDR);
        w_pending = {1'b0, r_outValid} + {1'b0, r_skidValid} + {1'b0, r_inFlight};
        w_rdAddr  = {r_k[DIM_LOG2-1:0], r_k[ADDR_WIDTH-1:DIM_LOG2]};
        w_read    = !reset && (r_state == DRAIN) && (r_k < WORDS_K)
                    && ((w_pending - {1'b0, w_outHs}) < 2'd2);
    end

    // RAM request and stream outputs. Address and data are forced to zero
    // when no access is made so the bus is quiet between transactions.
    always_comb begin
        bus.ram_we    = w_write;
        bus.ram_din   = w_write ? bus.in_data : '0;
        bus.ram_addr  = w_write ? r_wrCnt : (w_read ? w_rdAddr : '0);
        bus.in_ready  = !reset && (r_state == LOAD);
        bus.out_valid = r_outValid;
        bus.out_data  = r_outData;
        bus.done      = r_done;
    end

    // Controller state, counters and output FIFO. The state machine returns
    // to LOAD in the same edge that raises done, so a new matrix can start
    // immediately. The FIFO pushes the RAM word one cycle after its read and
    // pops on an output handshake; when both happen with the skid register
    // occupied, the skid word moves forward and the new word takes its place.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= LOAD;
            r_wrCnt     <= '0;
            r_k         <= '0;
            r_outCnt    <= '0;
            r_inFlight  <= 1'b0;
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inFlight <= w_read;

            if (w_read) begin
                r_k <= r_k + (ADDR_WIDTH + 1)'(1);
            end

            case (r_state)
                LOAD: begin
                    if (w_write) begin
                        if (r_wrCnt == LAST_ADDR) begin
                            r_wrCnt <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_wrCnt <= r_wrCnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_lastOut) begin
                        r_outCnt <= '0;
                        r_k      <= '0;
                        r_done   <= 1'b1;
                        r_state  <= LOAD;
                    end else if (w_outHs) begin
                        r_outCnt <= r_outCnt + ADDR_WIDTH'(1);
                    end
                end
                default: r_state <= LOAD;
            endcase

            if (w_outHs) begin
                if (r_skidValid) begin
                    r_outData   <= r_skidData;
                    r_skidValid <= r_inFlight;
                    if (r_inFlight) begin
                        r_skidData <= bus.ram_q;
                    end
                end else begin
                    r_outValid <= r_inFlight;
                    if (r_inFlight) begin
                        r_outData <= bus.ram_q;
                    end
                end
            end else if (r_inFlight) begin
                if (!r_outValid) begin
                    r_outValid <= 1'b1;
                    r_outData  <= bus.ram_q;
                end else begin
                    r_skidValid <= 1'b1;
                    r_skidData  <= bus.ram_q;
                end
            end
        end
    end
endmodule

// File: doc/transpose_ctrl.md
TRANSPOSE_CTRL -- requirements
Module: transpose_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the element width in bits.
REQ-002 The block SHALL have parameter DIM_LOG2, default 3, meaning log2 of matrix dimension N (N = 2**DIM_LOG2).
REQ-003 The block SHALL have derived localparam ADDR_WIDTH = 2*DIM_LOG2, meaning the RAM address width (N*N words).
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  DATA_WIDTH  input element, row-major order.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_data  output  DATA_WIDTH  transposed element.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 done  output  1  one-cycle pulse after the last transposed element is accepted.
REQ-013 ram_addr  output  ADDR_WIDTH  single-port RAM address.
REQ-014 ram_din  output  DATA_WIDTH  RAM write data.
REQ-015 ram_we  output  1  RAM write enable.
REQ-016 ram_q  input  DATA_WIDTH  RAM read data, valid exactly 1 cycle after the address is presented with ram_we=0.

Function
REQ-017 The block SHALL implement two states, LOAD and DRAIN; only one RAM access (write or read) SHALL occur per cycle.
REQ-018 In LOAD, in_ready SHALL be 1; on in_valid&&in_ready, ram_we=1, ram_din=in_data, ram_addr=wr_cnt, and wr_cnt SHALL increment.
REQ-019 When the accepted word has wr_cnt = N*N-1, wr_cnt SHALL wrap to 0 and the state SHALL become DRAIN next cycle.
REQ-020 In DRAIN, in_ready SHALL be 0 and ram_we SHALL be 0.
REQ-021 Output index k (0..N*N-1) with r = k div N, c = k mod N SHALL read ram_addr = c*N + r (bit-swap of the two DIM_LOG2 halves of k).
REQ-022 Output storage SHALL be a 2-entry FIFO (output register plus skid register); ram_q SHALL be written into it the cycle after a read is issued.
REQ-023 A read SHALL be issued in a cycle iff k < N*N and (FIFO occupancy + reads in flight - out handshake this cycle) < 2.
REQ-024 With out_ready held 1, DRAIN SHALL deliver one element per cycle after a 2-cycle startup (first out_valid 2 cycles after DRAIN entry).
REQ-025 out_data/out_valid SHALL hold stable while out_valid=1 and out_ready=0; no element SHALL be dropped or duplicated.
REQ-026 When the N*N-th element handshakes on the output, done SHALL pulse 1 for the next cycle, all counters SHALL be 0, and the state SHALL return to LOAD that cycle.
REQ-027 Idle cycles (in_valid=0 in LOAD, out_ready=0 in DRAIN) SHALL not advance any counter.
REQ-028 When no access is issued, ram_we SHALL be 0; ram_addr/ram_din values are don't-care.

Reset
REQ-029 On reset=1 at a clock edge: state=LOAD, wr_cnt=0, k=0, FIFO empty, in-flight cleared, out_valid=0, done=0, ram_we=0, out_data=0, ram_addr=0, ram_din=0.
REQ-030 Reset asserted mid-LOAD or mid-DRAIN SHALL abandon the current matrix; in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-031 Load 64 words value=index (0..63) with in_valid held 1, out_ready=1 -> ram_we high 64 cycles with addr 0..63, then outputs 0,8,16,...,56,1,9,...,63 one per cycle, done pulses once.
REQ-032 Drain with out_ready toggling 1,0,1,0 and random 3-cycle stalls -> identical output sequence, out_data stable during stalls, exactly 64 handshakes.
REQ-033 in_valid randomly deasserted during LOAD -> only accepted words written, DRAIN entered after 64th handshake, in_ready=0 thereafter until done.
REQ-034 reset pulsed after 30 LOAD words -> next matrix loads from addr 0; output is transpose of new matrix only.
REQ-035 reset pulsed while out_valid=1 and out_ready=0 mid-DRAIN -> out_valid=0 next cycle, state LOAD, no done pulse.
REQ-036 Two back-to-back matrices with DIM_LOG2=2 -> 16-word transpose each, done pulses twice, in_ready=1 the cycle after each done.
